mux_simples: RTL and testbench
==============================

Name: mux_simples

Overview:
- Parameterised 2:1 multiplexer. Basic building block for wider mux trees; three instances form a 4:1 mux, with s[0] driving the leaf level and s[1] driving the root.
- The primary output y is purely combinational, so trees of instances settle within the same time step.
- A registered copy of the output is provided for pipelined users. Registered outputs use one clock and a synchronous, active-high reset.

Parameters:
- WIDTH, default 1, data width of a, b, y and y_q in bits (legal range 1..64).

Ports:
- clock  input  1  system clock, rising-edge active.
- reset  input  1  synchronous active-high reset, affects registered outputs only.
- a  input  WIDTH  data input selected when s=0.
- b  input  WIDTH  data input selected when s=1.
- s  input  1  select.
- en  input  1  load enable for the registered output stage.
- y  output  WIDTH  combinational mux output.
- y_q  output  WIDTH  registered mux output.
- s_q  output  1  registered copy of the select captured with y_q.

Behaviour:
- Combinational path:
  - y = a when s=0; y = b when s=1.
  - Pure combinational, no latches, zero-cycle latency.
  - Changes on a, b or s propagate to y in the same time step.
  - y does not depend on clock, reset or en.
- Unused input: the input that is not selected has no effect on y. For example, with s=0, toggling b leaves y unchanged.
- Registered path, on each rising edge of clock:
  - If reset=1: y_q <= 0 and s_q <= 0.
  - Else if en=1: y_q <= y (the value from the same edge's inputs) and s_q <= s.
  - Else: y_q and s_q hold their values.
- Latency: y_q reflects the inputs one cycle after an enabled edge.
- Reset priority: reset overrides en. Asserting reset mid-stream clears y_q and s_q at the next edge regardless of en; y keeps tracking its inputs during reset.
- Power-up: y_q and s_q are undefined until the first reset edge. The bench applies reset before checking them.
- Width rule: all data ports are exactly WIDTH bits. There is no extension or truncation, and each bit is selected independently.
- Tree composition:
  - Three instances (m0 over a,b; m1 over c,d; both with s[0]; root over m0.y,m1.y with s[1]) implement a 4:1 mux.
  - Select mapping for S = {s[1],s[0]}: S=0 -> a, S=1 -> b, S=2 -> c, S=3 -> d.

Test Plan:
- Single instance, WIDTH=1, s=0, sweep (a,b) over {00,10,01,11} -> y equals a each step: 0,1,0,1.
- Single instance, s=1, same sweep -> y equals b: 0,0,1,1. With s=1, a=1, b=0 -> y=0.
- 4:1 tree, for each S in 0..3, apply one-hot patterns over a,b,c,d plus all-zero -> y=1 only when the hot input matches S. Examples: S=2 with c=1 -> y=1; S=2 with d=1 -> y=0; all-zero -> y=0.
- Registered path, WIDTH=8: reset for 1 edge -> y_q=0x00, s_q=0. Then en=1, a=0x5A, s=0 -> y_q=0x5A after 1 edge. Then s=1, b=0xC3 -> y_q=0xC3 and s_q=1 after the next edge.
- Hold and priority: en=0 while inputs change -> y_q holds 0xC3. Then reset=1 with en=1 -> y_q=0x00 and s_q=0 at the next edge, while y still shows the current combinational selection.

Source files
------------

// File: rtl/mux_simples_if.sv
// Signal bundle for one 2:1 mux instance: data inputs, select, load enable and outputs.
// Latency: none, this is wiring only.
// Backpressure: none; the bundle carries no flow control.
//
// Signals:
//   a, b  data inputs (WIDTH bits); a is chosen when s=0, b when s=1
//   s     select
//   en    load enable for the registered stage
//   y     combinational mux output (WIDTH bits)
//   y_q   registered mux output (WIDTH bits)
//   s_q   registered copy of s, captured together with y_q
// Modports: master drives the inputs and reads the outputs; slave is the mux itself.
interface mux_simples_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             s;
    logic             en;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;
    logic             s_q;

    modport master (
        output a, b, s, en,
        input  y, y_q, s_q
    );

    modport slave (
        input  a, b, s, en,
        output y, y_q, s_q
    );
endinterface

// File: rtl/mux_simples.sv
// Parameterised 2:1 mux with a combinational output and an enable-loaded registered copy.
// Latency: y is zero-cycle; y_q and s_q follow one cycle after an enabled clock edge.
// Backpressure: none; en only gates loading of the register stage, it never stalls y.
//
// Ports:
//   clock  rising-edge system clock (registered stage only)
//   reset  synchronous active-high reset; clears y_q and s_q, takes priority over en
//   bus    mux_simples_if slave modport carrying a, b, s, en, y, y_q, s_q
// WIDTH must match the WIDTH of the connected interface instance (legal range 1..64).
module mux_simples #(
    parameter int WIDTH = 1
) (
    input  logic          clock,
    input  logic          reset,
    mux_simples_if.slave  bus
);

    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] r_y_q;
    logic             r_s_q;

    // Per-bit select; the unselected input has no path to y, and y does not
    // depend on clock, reset or en, so trees of instances settle in one time step.
    assign w_y = bus.s ? bus.b : bus.a;

    // Reset is checked first so a mid-stream reset wins over an active load.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_y_q <= '0;
            r_s_q <= 1'b0;
        end else if (bus.en) begin
            r_y_q <= w_y;
            r_s_q <= bus.s;
        end
    end

    assign bus.y   = w_y;
    assign bus.y_q = r_y_q;
    assign bus.s_q = r_s_q;

endmodule

// File: tb/tb_mux_simples.sv
// Scoreboard bench for mux_simples: single 1-bit instance, 4:1 tree of three instances, 8-bit registered path.
// Latency: combinational expectations are checked at the negedge after the inputs change; registered ones after the enabled edge.
// Backpressure: none; the stimulus waits for the scoreboard queue to drain before finishing.
module tb_mux_simples;

    logic clock;
    logic reset;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single 1-bit instance
    mux_simples_if #(.WIDTH(1)) if_w1 ();
    mux_simples #(.WIDTH(1)) u_w1 (.clock(clock), .reset(reset), .bus(if_w1.slave));

    // 4:1 tree: m0 over a,b and m1 over c,d share sel[0]; root picks with sel[1]
    logic [1:0] r_sel;
    logic       r_ta, r_tb, r_tc, r_td;
    mux_simples_if #(.WIDTH(1)) if_m0 ();
    mux_simples_if #(.WIDTH(1)) if_m1 ();
    mux_simples_if #(.WIDTH(1)) if_rt ();
    assign if_m0.a  = r_ta;
    assign if_m0.b  = r_tb;
    assign if_m0.s  = r_sel[0];
    assign if_m0.en = 1'b0;
    assign if_m1.a  = r_tc;
    assign if_m1.b  = r_td;
    assign if_m1.s  = r_sel[0];
    assign if_m1.en = 1'b0;
    assign if_rt.a  = if_m0.y;
    assign if_rt.b  = if_m1.y;
    assign if_rt.s  = r_sel[1];
    assign if_rt.en = 1'b0;
    mux_simples #(.WIDTH(1)) u_m0 (.clock(clock), .reset(reset), .bus(if_m0.slave));
    mux_simples #(.WIDTH(1)) u_m1 (.clock(clock), .reset(reset), .bus(if_m1.slave));
    mux_simples #(.WIDTH(1)) u_rt (.clock(clock), .reset(reset), .bus(if_rt.slave));

    // 8-bit instance for the registered path
    mux_simples_if #(.WIDTH(8)) if_w8 ();
    mux_simples #(.WIDTH(8)) u_w8 (.clock(clock), .reset(reset), .bus(if_w8.slave));

    // Scoreboard: which observed output an entry refers to
    localparam int SEL_Y1  = 0;
    localparam int SEL_YT  = 1;
    localparam int SEL_Y8  = 2;
    localparam int SEL_YQ8 = 3;
    localparam int SEL_SQ8 = 4;

    typedef struct {
        string      name;
        int         sel;
        logic [7:0] exp;
    } exp_t;

    exp_t q_exp[$];
    int   n_tests;
    int   n_fail;

    task automatic push(input string name, input int sel, input logic [7:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        q_exp.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: drains every pending expectation at the negedge, away from the active edge
    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(negedge clock);
            while (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                case (e.sel)
                    SEL_Y1:  act = {7'd0, if_w1.y};
                    SEL_YT:  act = {7'd0, if_rt.y};
                    SEL_Y8:  act = if_w8.y;
                    SEL_YQ8: act = if_w8.y_q;
                    default: act = {7'd0, if_w8.s_q};
                endcase
                n_tests++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%02h, expected 0x%02h", e.name, act, e.exp);
                end
            end
        end
    end

    // Hand-computed vectors: {a,b} and the expected y for each select value
    logic [1:0] v_ab   [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    logic       v_y_s0 [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       v_y_s1 [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    // Tree patterns {d,c,b,a}: one-hot then all-zero
    logic [3:0] v_pat  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    // Expected tree output indexed [S][pattern]
    logic       v_tree [4][5] = '{
        '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
        '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
        '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
        '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0}
    };

    initial begin
        logic [1:0] ab;
        logic [3:0] pat;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        if_w1.a = 1'b0; if_w1.b = 1'b0; if_w1.s = 1'b0; if_w1.en = 1'b0;
        if_w8.a = 8'h00; if_w8.b = 8'h00; if_w8.s = 1'b0; if_w8.en = 1'b0;
        r_sel = 2'd0;
        r_ta = 1'b0; r_tb = 1'b0; r_tc = 1'b0; r_td = 1'b0;
        step();

        // Single instance, s=0 then s=1, sweep (a,b)
        for (int i = 0; i < 4; i++) begin
            ab = v_ab[i];
            if_w1.s = 1'b0; if_w1.a = ab[1]; if_w1.b = ab[0];
            push($sformatf("w1_s0_ab%0d", i), SEL_Y1, {7'd0, v_y_s0[i]});
            step();
        end
        for (int i = 0; i < 4; i++) begin
            ab = v_ab[i];
            if_w1.s = 1'b1; if_w1.a = ab[1]; if_w1.b = ab[0];
            push($sformatf("w1_s1_ab%0d", i), SEL_Y1, {7'd0, v_y_s1[i]});
            step();
        end
        // Unused input: s=0, a=1, toggling b must not move y
        if_w1.s = 1'b0; if_w1.a = 1'b1; if_w1.b = 1'b0;
        push("w1_unused_b0", SEL_Y1, 8'h01);
        step();
        if_w1.b = 1'b1;
        push("w1_unused_b1", SEL_Y1, 8'h01);
        step();

        // 4:1 tree
        for (int s = 0; s < 4; s++) begin
            for (int p = 0; p < 5; p++) begin
                pat   = v_pat[p];
                r_sel = 2'(s);
                r_ta  = pat[0]; r_tb = pat[1]; r_tc = pat[2]; r_td = pat[3];
                push($sformatf("tree_S%0d_p%0d", s, p), SEL_YT, {7'd0, v_tree[s][p]});
                step();
            end
        end

        // Registered path, WIDTH=8
        reset = 1'b1; if_w8.en = 1'b0;
        step();
        push("rst_yq", SEL_YQ8, 8'h00);
        push("rst_sq", SEL_SQ8, 8'h00);
        reset = 1'b0; if_w8.en = 1'b1; if_w8.a = 8'h5A; if_w8.s = 1'b0;
        push("load1_y", SEL_Y8, 8'h5A);
        step();
        push("load1_yq", SEL_YQ8, 8'h5A);
        push("load1_sq", SEL_SQ8, 8'h00);
        if_w8.s = 1'b1; if_w8.b = 8'hC3;
        push("load2_y", SEL_Y8, 8'hC3);
        step();
        push("load2_yq", SEL_YQ8, 8'hC3);
        push("load2_sq", SEL_SQ8, 8'h01);

        // Hold: en=0 while inputs change
        if_w8.en = 1'b0; if_w8.s = 1'b0; if_w8.a = 8'h11; if_w8.b = 8'h22;
        push("hold_y", SEL_Y8, 8'h11);
        step();
        push("hold1_yq", SEL_YQ8, 8'hC3);
        push("hold1_sq", SEL_SQ8, 8'h01);
        if_w8.a = 8'h33;
        step();
        push("hold2_yq", SEL_YQ8, 8'hC3);

        // Priority: reset with en=1 clears, y keeps tracking
        reset = 1'b1; if_w8.en = 1'b1; if_w8.s = 1'b1; if_w8.b = 8'h77;
        push("prio_y_pre", SEL_Y8, 8'h77);
        step();
        push("prio_yq", SEL_YQ8, 8'h00);
        push("prio_sq", SEL_SQ8, 8'h00);
        push("prio_y", SEL_Y8, 8'h77);
        reset = 1'b0;

        // Let the monitor drain, bounded
        for (int k = 0; k < 4 && q_exp.size() > 0; k++) step();
        n_tests++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q_exp.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
